// File: rtl/snn_timestep_sequencer.sv
// Timestep sequencer for a spiking neuron layer: input handshake, integration window, delay pulse, spike capture/count.
// Optional run abort port is compiled in when SNN_SEQ_ABORT_EN is defined.
module snn_timestep_sequencer #(
  parameter int M     = 2,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_steps,
  input  logic [3:0]         settle_cycles,
  input  logic               in_valid,
  input  logic [M-1:0]       in_spikes,
  output logic               in_ready,
  input  logic [N-1:0]       layer_spikes,
  output logic               layer_enable,
  output logic               layer_delay_clk,
  output logic [M-1:0]       layer_input_spikes,
  output logic [N-1:0]       step_spikes,
  output logic               step_valid,
  output logic [N*CNT_W-1:0] spike_counts,
  output logic               busy,
  output logic               done
`ifdef SNN_SEQ_ABORT_EN
  ,
  input  logic               abort
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    RUN,
    DELAY,
    CAPTURE
  } state_t;

  state_t             state;
  logic [7:0]         steps_q;
  logic [3:0]         settle_q;
  logic [7:0]         step_idx;
  logic [3:0]         win_cnt;
  logic [N-1:0]       sticky;
  logic [N-1:0]       final_sticky;
  logic [N*CNT_W-1:0] counts_inc;
  logic               abort_hit;

`ifdef SNN_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // The sample taken in the current cycle still belongs to the step being closed.
  assign final_sticky = sticky | layer_spikes;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    counts_inc = spike_counts;
    for (int i = 0; i < N; i++) begin
      if (final_sticky[i] && (spike_counts[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        counts_inc[i*CNT_W +: CNT_W] = spike_counts[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      steps_q            <= '0;
      settle_q           <= '0;
      step_idx           <= '0;
      win_cnt            <= '0;
      sticky             <= '0;
      in_ready           <= 1'b0;
      layer_enable       <= 1'b0;
      layer_delay_clk    <= 1'b0;
      layer_input_spikes <= '0;
      step_spikes        <= '0;
      step_valid         <= 1'b0;
      spike_counts       <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      done       <= 1'b0;
      step_valid <= 1'b0;
      if (abort_hit) begin
        state              <= IDLE;
        in_ready           <= 1'b0;
        layer_enable       <= 1'b0;
        layer_delay_clk    <= 1'b0;
        layer_input_spikes <= '0;
        busy               <= 1'b0;
        done               <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (num_steps != 8'd0) begin
                steps_q      <= num_steps;
                settle_q     <= settle_cycles;
                spike_counts <= '0;
                step_idx     <= '0;
                in_ready     <= 1'b1;
                busy         <= 1'b1;
                state        <= WAIT_IN;
              end else begin
                done <= 1'b1;
              end
            end
          end
          WAIT_IN: begin
            if (in_valid) begin
              layer_input_spikes <= in_spikes;
              sticky             <= '0;
              win_cnt            <= '0;
              in_ready           <= 1'b0;
              layer_enable       <= 1'b1;
              state              <= RUN;
            end
          end
          RUN: begin
            sticky <= final_sticky;
            if (win_cnt == settle_q) begin
              layer_enable    <= 1'b0;
              layer_delay_clk <= 1'b1;
              state           <= DELAY;
            end else begin
              win_cnt <= win_cnt + 4'd1;
            end
          end
          DELAY: begin
            sticky          <= final_sticky;
            layer_delay_clk <= 1'b0;
            state           <= CAPTURE;
          end
          CAPTURE: begin
            step_spikes        <= final_sticky;
            step_valid         <= 1'b1;
            spike_counts       <= counts_inc;
            layer_input_spikes <= '0;
            if (step_idx == steps_q - 8'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              step_idx <= step_idx + 8'd1;
              in_ready <= 1'b1;
              state    <= WAIT_IN;
            end
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
